// File: rtl/drp_slave_regs_if.sv
// DRP bus bundle for drp_slave_regs: request (addr/en/we/di) and response (do/rdy).
interface drp_slave_regs_if;
    logic [6:0]  drp_addr;
    logic        drp_en;
    logic        drp_we;
    logic [15:0] drp_di;
    logic [15:0] drp_do;
    logic        drp_rdy;

    modport master (
        output drp_addr,
        output drp_en,
        output drp_we,
        output drp_di,
        input  drp_do,
        input  drp_rdy
    );

    modport slave (
        input  drp_addr,
        input  drp_en,
        input  drp_we,
        input  drp_di,
        output drp_do,
        output drp_rdy
    );
endinterface

// File: rtl/drp_slave_regs.sv
// DRP-attached register slave: eight read-only sample registers fed by a converter
// front end, a channel-0 threshold/alarm, and a sticky collision flag for requests
// that arrive while a transaction is still in flight.
//
// Optional feature: define DRP_SLV_AVG_EN to make SMP[0] (and the alarm comparison)
// use the moving average of the last four channel-0 samples instead of the raw value.
//
// U_DLY is accepted for compatibility with delay-annotated simulation flows; the
// synthesizable register updates here carry no delay.
module drp_slave_regs #(
    parameter int unsigned RD_LAT = 3,
    parameter int unsigned U_DLY  = 1
) (
    input  logic            clk_cfg,
    input  logic            rst_cfg_n,
    drp_slave_regs_if.slave drp,
    input  logic            smp_valid,
    input  logic [2:0]      smp_chan,
    input  logic [11:0]     smp_data,
    output logic            alarm
);

    // Elaboration-time parameter sanity checks.
    if (RD_LAT < 1 || RD_LAT > 15) begin : g_bad_rd_lat
        $error("drp_slave_regs: RD_LAT must be in 1..15");
    end
    if (U_DLY > 100) begin : g_bad_u_dly
        $error("drp_slave_regs: U_DLY is unreasonably large");
    end

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StDone
    } state_e;

    localparam logic [6:0] ThrAddr  = 7'h40;
    localparam logic [6:0] CfgAddr  = 7'h41;
    localparam logic [6:0] StatAddr = 7'h42;
    localparam logic [3:0] CntLoad  = 4'(RD_LAT - 1);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        capture;
    logic        wr_fire;
    logic        coll_set;
    logic        rdy;

    logic [6:0]  addr_q;
    logic        we_q;
    logic [15:0] di_q;

    logic [15:0] thr_q, thr_d;
    logic        cfg_q, cfg_d;
    logic        coll_q, coll_d;
    logic        alarm_q, alarm_d;

    logic [11:0] smp_q [8];
    logic        ch0_hit;
    logic [11:0] ch0_level;
    logic [11:0] smp0_view;
    logic [15:0] rd_data;

    assign ch0_hit = smp_valid && (smp_chan == 3'd0);

    // FSM state and latency counter; reset aborts any transaction in flight.
    always_ff @(posedge clk_cfg or negedge rst_cfg_n) begin
        if (!rst_cfg_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic; requests outside IDLE are dropped and flagged as collisions.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        capture  = 1'b0;
        coll_set = 1'b0;
        wr_fire  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (drp.drp_en) begin
                    capture = 1'b1;
                    cnt_d   = CntLoad;
                    if (RD_LAT == 1) begin
                        state_d = StDone;
                    end else begin
                        state_d = StBusy;
                    end
                end
            end
            StBusy: begin
                coll_set = drp.drp_en;
                if (cnt_q <= 4'd1) begin
                    cnt_d   = '0;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StDone: begin
                coll_set = drp.drp_en;
                wr_fire  = we_q;
                state_d  = StIdle;
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    // Request capture; held stable through BUSY and DONE.
    always_ff @(posedge clk_cfg or negedge rst_cfg_n) begin
        if (!rst_cfg_n) begin
            addr_q <= '0;
            we_q   <= 1'b0;
            di_q   <= '0;
        end else if (capture) begin
            addr_q <= drp.drp_addr;
            we_q   <= drp.drp_we;
            di_q   <= drp.drp_di;
        end
    end

    // Register-file writes land on the edge closing DONE; a new collision beats a W1C.
    always_comb begin
        thr_d  = thr_q;
        cfg_d  = cfg_q;
        coll_d = coll_q;
        if (wr_fire) begin
            case (addr_q)
                ThrAddr:  thr_d = di_q;
                CfgAddr:  cfg_d = di_q[0];
                StatAddr: begin
                    if (di_q[1]) begin
                        coll_d = 1'b0;
                    end
                end
                default: ;
            endcase
        end
        if (coll_set) begin
            coll_d = 1'b1;
        end
    end

    // Alarm tracks channel-0 samples while enabled and drops as soon as it is disabled.
    always_comb begin
        alarm_d = alarm_q;
        if (!cfg_q) begin
            alarm_d = 1'b0;
        end else if (ch0_hit) begin
            alarm_d = ({ch0_level, 4'h0} >= thr_q);
        end
    end

    // Control/status registers and alarm flag.
    always_ff @(posedge clk_cfg or negedge rst_cfg_n) begin
        if (!rst_cfg_n) begin
            thr_q   <= 16'hFFF0;
            cfg_q   <= 1'b0;
            coll_q  <= 1'b0;
            alarm_q <= 1'b0;
        end else begin
            thr_q   <= thr_d;
            cfg_q   <= cfg_d;
            coll_q  <= coll_d;
            alarm_q <= alarm_d;
        end
    end

    // Sample registers, written straight from the front end regardless of DRP activity.
    always_ff @(posedge clk_cfg or negedge rst_cfg_n) begin
        if (!rst_cfg_n) begin
            for (int i = 0; i < 8; i++) begin
                smp_q[i] <= '0;
            end
        end else if (smp_valid) begin
            smp_q[smp_chan] <= smp_data;
        end
    end

`ifdef DRP_SLV_AVG_EN
    // smp_q[0] is the newest channel-0 sample; hist_q holds the three before it.
    logic [11:0] hist_q [3];
    logic [13:0] sum_now;
    logic [13:0] sum_next;

    // Channel-0 history shift register.
    always_ff @(posedge clk_cfg or negedge rst_cfg_n) begin
        if (!rst_cfg_n) begin
            for (int i = 0; i < 3; i++) begin
                hist_q[i] <= '0;
            end
        end else if (ch0_hit) begin
            hist_q[0] <= smp_q[0];
            hist_q[1] <= hist_q[0];
            hist_q[2] <= hist_q[1];
        end
    end

    // Current average for reads, and the average including the incoming sample for alarm.
    always_comb begin
        sum_now   = 14'(smp_q[0]) + 14'(hist_q[0]) + 14'(hist_q[1]) + 14'(hist_q[2]);
        sum_next  = 14'(smp_data) + 14'(smp_q[0]) + 14'(hist_q[0]) + 14'(hist_q[1]);
        smp0_view = 12'(sum_now >> 2);
        ch0_level = 12'(sum_next >> 2);
    end
`else
    // Raw channel-0 value for both reads and alarm.
    always_comb begin
        smp0_view = smp_q[0];
        ch0_level = smp_data;
    end
`endif

    // Read mux over the captured address; unmapped addresses read as zero.
    always_comb begin
        rd_data = '0;
        if (addr_q[6:3] == 4'h0) begin
            if (addr_q[2:0] == 3'd0) begin
                rd_data = {smp0_view, 4'h0};
            end else begin
                rd_data = {smp_q[addr_q[2:0]], 4'h0};
            end
        end else begin
            case (addr_q)
                ThrAddr:  rd_data = thr_q;
                CfgAddr:  rd_data = {15'h0000, cfg_q};
                StatAddr: rd_data = {14'h0000, coll_q, alarm_q};
                default:  rd_data = '0;
            endcase
        end
    end

    assign rdy         = (state_q == StDone);
    assign drp.drp_rdy = rdy;
    assign drp.drp_do  = rdy ? rd_data : 16'h0000;
    assign alarm       = alarm_q;

endmodule

// File: tb/tb_drp_slave_regs.sv
// Directed bench for drp_slave_regs (RD_LAT=3); expected values are hand-computed.
module tb_drp_slave_regs;

    localparam int unsigned RdLat = 3;

`ifdef DRP_SLV_AVG_EN
    localparam logic        AlarmHitExp = 1'b0;   // averaged level stays below 0x8000
    localparam logic [15:0] Smp0Exp     = 16'h2800;
`else
    localparam logic        AlarmHitExp = 1'b1;
    localparam logic [15:0] Smp0Exp     = 16'h4000;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        smp_valid = 1'b0;
    logic [2:0]  smp_chan = 3'd0;
    logic [11:0] smp_data = 12'h000;
    logic        alarm;

    int n_cmp = 0;
    int n_bad = 0;

    drp_slave_regs_if bus ();

    drp_slave_regs #(
        .RD_LAT (RdLat),
        .U_DLY  (1)
    ) dut (
        .clk_cfg   (clk),
        .rst_cfg_n (rst_n),
        .drp       (bus),
        .smp_valid (smp_valid),
        .smp_chan  (smp_chan),
        .smp_data  (smp_data),
        .alarm     (alarm)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one request at the current negedge and watch an 8-cycle window.
    task automatic drp_xact(input logic [6:0] a, input logic we, input logic [15:0] di,
                            input int dup_at, input logic inj, input logic [2:0] inj_ch,
                            input logic [11:0] inj_d, output logic [15:0] rdata,
                            output int lat, output int pulses, output logic leak);
        rdata  = '0;
        lat    = -1;
        pulses = 0;
        leak   = 1'b0;
        bus.drp_addr = a;
        bus.drp_we   = we;
        bus.drp_di   = di;
        bus.drp_en   = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (bus.drp_rdy === 1'b1) begin
                pulses++;
                if (lat < 0) begin
                    lat   = i;
                    rdata = bus.drp_do;
                end
            end else if (bus.drp_do !== 16'h0000) begin
                leak = 1'b1;
            end
            bus.drp_en = (i == dup_at);
            bus.drp_we = 1'b0;
            smp_valid  = inj && (i == 1);
            smp_chan   = inj_ch;
            smp_data   = inj_d;
        end
        bus.drp_en = 1'b0;
        smp_valid  = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [6:0] a, input logic [15:0] exp);
        logic [15:0] d;
        int          l;
        int          p;
        logic        k;
        drp_xact(a, 1'b0, 16'h0000, 0, 1'b0, 3'd0, 12'h000, d, l, p, k);
        check({tag, ".data"}, 32'(d), 32'(exp));
    endtask

    task automatic wr(input string tag, input logic [6:0] a, input logic [15:0] v);
        logic [15:0] d;
        int          l;
        int          p;
        logic        k;
        drp_xact(a, 1'b1, v, 0, 1'b0, 3'd0, 12'h000, d, l, p, k);
        check({tag, ".pulses"}, 32'(p), 32'd1);
    endtask

    // One-cycle sample strobe; returns at the negedge after the capturing edge.
    task automatic sample(input logic [2:0] ch, input logic [11:0] v);
        smp_valid = 1'b1;
        smp_chan  = ch;
        smp_data  = v;
        @(negedge clk);
        smp_valid = 1'b0;
    endtask

    initial begin
        logic [15:0] d;
        int          l;
        int          p;
        int          ab;
        logic        k;

        bus.drp_addr = '0;
        bus.drp_en   = 1'b0;
        bus.drp_we   = 1'b0;
        bus.drp_di   = '0;
        #1 rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_rdy", 32'(bus.drp_rdy), 32'd0);
        check("rst_do", 32'(bus.drp_do), 32'd0);
        check("rst_alarm", 32'(alarm), 32'd0);

        // Release and request in the same cycle: first clock with reset high accepts it.
        rst_n = 1'b1;
        drp_xact(7'h40, 1'b0, 16'h0000, 0, 1'b0, 3'd0, 12'h000, d, l, p, k);
        check("thr_rst.data", 32'(d), 32'h0000_FFF0);
        check("thr_rst.lat", 32'(l), 32'(RdLat));
        check("thr_rst.pulses", 32'(p), 32'd1);
        check("thr_rst.do_idle", 32'(k), 32'd0);

        sample(3'd3, 12'hABC);
        rd("smp3", 7'h03, 16'hABC0);
        drp_xact(7'h55, 1'b0, 16'h0000, 0, 1'b0, 3'd0, 12'h000, d, l, p, k);
        check("unmapped.data", 32'(d), 32'd0);
        check("unmapped.pulses", 32'(p), 32'd1);
        rd("smp0_rst", 7'h00, 16'h0000);
        rd("cfg_rst", 7'h41, 16'h0000);
        rd("stat_rst", 7'h42, 16'h0000);

        wr("wr_cfg", 7'h41, 16'h0001);
        wr("wr_thr", 7'h40, 16'h8000);
        rd("thr", 7'h40, 16'h8000);
        rd("cfg", 7'h41, 16'h0001);
        wr("wr_ro", 7'h03, 16'hFFFF);
        rd("smp3_ro", 7'h03, 16'hABC0);
        wr("wr_unmapped", 7'h55, 16'h1234);

        // Sample landing during BUSY must show up in the read data.
        drp_xact(7'h05, 1'b0, 16'h0000, 0, 1'b1, 3'd5, 12'h321, d, l, p, k);
        check("smp5_busy.data", 32'(d), 32'h0000_3210);

        check("alarm_pre", 32'(alarm), 32'd0);
        sample(3'd0, 12'h800);
        check("alarm_hit", 32'(alarm), 32'(AlarmHitExp));
        @(negedge clk);
        check("alarm_hold", 32'(alarm), 32'(AlarmHitExp));
        sample(3'd0, 12'h7FF);
        check("alarm_low", 32'(alarm), 32'd0);
        sample(3'd0, 12'h800);
        check("alarm_hit2", 32'(alarm), 32'(AlarmHitExp));
        wr("cfg_off", 7'h41, 16'h0000);
        check("alarm_disable", 32'(alarm), 32'd0);
        sample(3'd0, 12'hFFF);
        check("alarm_off_smp", 32'(alarm), 32'd0);

        // Second strobe one cycle after acceptance: ignored, flagged as collision.
        drp_xact(7'h40, 1'b0, 16'h0000, 1, 1'b0, 3'd0, 12'h000, d, l, p, k);
        check("coll.pulses", 32'(p), 32'd1);
        check("coll.data", 32'(d), 32'h0000_8000);
        rd("stat_coll", 7'h42, 16'h0002);

        // W1C in DONE while another strobe collides: set wins.
        drp_xact(7'h42, 1'b1, 16'h0002, 3, 1'b0, 3'd0, 12'h000, d, l, p, k);
        check("prio.pulses", 32'(p), 32'd1);
        rd("stat_prio", 7'h42, 16'h0002);
        wr("w1c", 7'h42, 16'h0002);
        rd("stat_clr", 7'h42, 16'h0000);

        // Reset during BUSY of a THR0 write: no completion, write discarded.
        bus.drp_addr = 7'h40;
        bus.drp_we   = 1'b1;
        bus.drp_di   = 16'h1234;
        bus.drp_en   = 1'b1;
        @(negedge clk);
        bus.drp_en = 1'b0;
        bus.drp_we = 1'b0;
        rst_n      = 1'b0;
        @(negedge clk);
        check("abort_rdy_in_rst", 32'(bus.drp_rdy), 32'd0);
        rst_n = 1'b1;
        ab    = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.drp_rdy === 1'b1) ab++;
        end
        check("abort_pulses", 32'(ab), 32'd0);
        rd("abort_thr", 7'h40, 16'hFFF0);
        rd("abort_cfg", 7'h41, 16'h0000);

        sample(3'd0, 12'h100);
        sample(3'd0, 12'h200);
        sample(3'd0, 12'h300);
        sample(3'd0, 12'h400);
        rd("smp0_final", 7'h00, Smp0Exp);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/drp_slave_regs.md
DRP_SLAVE_REGS -- requirements
Module: drp_slave_regs

Interface
REQ-001 SHALL have parameter RD_LAT, default 3, legal range 1..15: cycles from accepted drp_en to drp_rdy.
REQ-002 SHALL have parameter U_DLY, default 1: simulation delay on all register assignments.
REQ-003 SHALL have port clk_cfg  input  1  single clock; all logic is clocked on its rising edge.
REQ-004 SHALL have port rst_cfg_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port drp_addr  input  7  DRP register address.
REQ-006 SHALL have port drp_en  input  1  one-cycle DRP request strobe.
REQ-007 SHALL have port drp_we  input  1  write qualifier, sampled with drp_en.
REQ-008 SHALL have port drp_di  input  16  write data, sampled with drp_en.
REQ-009 SHALL have port drp_do  output  16  read data, valid only while drp_rdy=1.
REQ-010 SHALL have port drp_rdy  output  1  one-cycle completion strobe for reads and writes.
REQ-011 SHALL have port smp_valid  input  1  sample strobe from the converter front end.
REQ-012 SHALL have port smp_chan  input  3  sample channel index, 0..7.
REQ-013 SHALL have port smp_data  input  12  raw sample value.
REQ-014 SHALL have port alarm  output  1  channel-0 over-threshold flag.

Function
REQ-015 SHALL use this register map: 0x00-0x07 SMP[n], read-only, {sample,4'h0}; 0x40 THR0, RW, reset 16'hFFF0; 0x41 CFG, RW, bit0 = alarm_en, reset 0; 0x42 STAT: bit0 = alarm (RO), bit1 = collision (sticky, write-1-to-clear).
REQ-016 SHALL return 16'h0000 on reads of unmapped addresses, and SHALL ignore writes to unmapped and read-only addresses while still completing them with drp_rdy.
REQ-017 SHALL implement FSM IDLE -> BUSY -> DONE -> IDLE.
REQ-018 In IDLE, drp_en=1 SHALL capture addr, we and di, load a down-counter with RD_LAT-1, and enter BUSY; if RD_LAT=1 the FSM SHALL go straight to DONE.
REQ-019 In BUSY, the counter SHALL decrement each cycle, and the FSM SHALL enter DONE when the counter reaches 0.
REQ-020 In DONE, drp_rdy SHALL be 1 for exactly one cycle and the FSM SHALL return to IDLE; drp_rdy therefore rises exactly RD_LAT cycles after the drp_en cycle.
REQ-021 Read data SHALL be the register contents in the DONE cycle (a sample update during BUSY is visible); drp_do SHALL be 16'h0000 whenever drp_rdy=0.
REQ-022 A write SHALL update its target register on the clock edge that ends the DONE cycle.
REQ-023 drp_en=1 while the FSM is in BUSY or DONE SHALL be ignored (no response) and SHALL set STAT.collision.
REQ-024 When a collision and a W1C of STAT.collision occur in the same cycle, set SHALL take priority.
REQ-025 smp_valid=1 SHALL write smp_data into SMP[smp_chan] on the next edge, independent of the DRP FSM.
REQ-026 alarm SHALL be updated one cycle after a channel-0 sample to (alarm_en & ({smp_data,4'h0} >= THR0)).
REQ-027 Clearing alarm_en SHALL drive alarm to 0 on the next edge.
REQ-028 alarm SHALL hold its value between channel-0 samples.

Reset
REQ-029 While rst_cfg_n=0, the block SHALL force: FSM = IDLE, counter = 0, drp_rdy = 0, drp_do = 0, alarm = 0, SMP[0..7] = 0, THR0 = 16'hFFF0, CFG = 0, STAT = 0.
REQ-030 A reset asserted mid-transaction SHALL abort it with no drp_rdy issued, and any pending write SHALL be discarded.
REQ-031 After release, the first drp_en SHALL be accepted in the first clock in which rst_cfg_n=1.

Configuration
REQ-032 With macro DRP_SLV_AVG_EN defined, SMP[0] SHALL read as the 4-sample moving average of channel 0 (sum of the last four samples >> 2, 14-bit sum, history cleared to 0 at reset), and alarm SHALL compare this average against THR0.
REQ-033 Without DRP_SLV_AVG_EN, SMP[0] SHALL hold the last raw channel-0 sample, and the averaging logic SHALL be absent.

Verification
REQ-034 With RD_LAT=3: reset, then read 0x40 -> drp_rdy exactly 3 cycles after drp_en, drp_do=16'hFFF0, and drp_do=0 in all other cycles.
REQ-035 Sample ch3=12'hABC, then read 0x03 -> drp_do=16'hABC0; read 0x55 -> drp_do=16'h0000 with drp_rdy pulse.
REQ-036 Write 0x41=1 and 0x40=16'h8000, then ch0 sample 12'h800 -> alarm=1 next cycle; ch0 sample 12'h7FF -> alarm=0.
REQ-037 Issue drp_en one cycle after an accepted request -> single drp_rdy only and STAT reads 16'h0002; write 0x42=16'h0002 -> STAT reads 0.
REQ-038 Assert rst_cfg_n=0 during BUSY of a write to 0x40 -> no drp_rdy, and THR0 reads 16'hFFF0 after release.
REQ-039 With DRP_SLV_AVG_EN defined: ch0 samples 0x100, 0x200, 0x300, 0x400 -> SMP[0] reads 16'h2800.
